// File: rtl/univ_sreg_pkg.sv
// rtl/univ_sreg_pkg.sv - mode and FSM state encodings shared by univ_sreg files
// Purpose: single source for the operation codes and controller state encoding.
// Ports: none (package).
// Optional feature macro: UNIV_SREG_PARITY_EN (not referenced here).
package univ_sreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/univ_sreg_if.sv
// rtl/univ_sreg_if.sv - command/data bundle between a host and univ_sreg
// Purpose: groups the command, serial/parallel data and status signals.
// Signals: start, mode[2:0], cnt[CW-1:0], sin[W-1:0], pin[N*W-1:0] (host -> reg);
//          out[N*W-1:0], sout[W-1:0], busy, done, and par when
//          UNIV_SREG_PARITY_EN is defined (reg -> host).
// Modports: master (host side), slave (register side).
interface univ_sreg_if #(
  parameter int N  = 4,
  parameter int W  = 1,
  parameter int CW = 8
);
  logic           start;
  logic [2:0]     mode;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   sin;
  logic [N*W-1:0] pin;
  logic [N*W-1:0] out;
  logic [W-1:0]   sout;
  logic           busy;
  logic           done;
`ifdef UNIV_SREG_PARITY_EN
  logic           par;

  modport master (output start, mode, cnt, sin, pin,
                  input  out, sout, busy, done, par);
  modport slave  (input  start, mode, cnt, sin, pin,
                  output out, sout, busy, done, par);
`else
  modport master (output start, mode, cnt, sin, pin,
                  input  out, sout, busy, done);
  modport slave  (input  start, mode, cnt, sin, pin,
                  output out, sout, busy, done);
`endif
endinterface

// File: rtl/univ_sreg_ctrl.sv
// rtl/univ_sreg_ctrl.sv - command FSM and down-counter for univ_sreg
// Purpose: accepts a command in IDLE, runs it for the effective count, pulses done.
// Ports: ck, rn (async active-low); start, mode[2:0], cnt[CW-1:0] in;
//        accept (command taken this cycle), busy, done, step (apply op on
//        this edge), mode_lat[2:0] (latched mode) out.
module univ_sreg_ctrl
  import univ_sreg_pkg::*;
#(
  parameter int CW = 8
) (
  input  logic          ck,
  input  logic          rn,
  input  logic          start,
  input  logic [2:0]    mode,
  input  logic [CW-1:0] cnt,
  output logic          accept,
  output logic          busy,
  output logic          done,
  output logic          step,
  output logic [2:0]    mode_lat
);

  state_t        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic [2:0]    mode_q, mode_d;
  logic [CW-1:0] eff_cnt;

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      mode_q  <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    mode_d  = mode_q;
    // LOAD always takes exactly one operation regardless of cnt
    eff_cnt = (mode == MODE_LOAD) ? CW'(1) : cnt;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode;
          rem_d   = eff_cnt;
          state_d = (eff_cnt != '0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        rem_d = rem_q - CW'(1);
        if (rem_q == CW'(1)) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept   = (state_q == ST_IDLE) && start;
    busy     = (state_q == ST_RUN);
    done     = (state_q == ST_DONE);
    step     = (state_q == ST_RUN);
    mode_lat = mode_q;
  end

endmodule

// File: rtl/univ_sreg.sv
// rtl/univ_sreg.sv - N-lane x W-bit universal shift/rotate/load register
// Purpose: lane datapath, parallel-load latch and serial-out mux around univ_sreg_ctrl.
// Ports: ck (rising edge), rn (async active-low reset), bus (univ_sreg_if.slave):
//        start/mode/cnt/sin/pin in; out/sout/busy/done out.
// Optional feature macro: UNIV_SREG_PARITY_EN adds bus.par = registered ^out.
module univ_sreg
  import univ_sreg_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 1,
  parameter int CW = 8
) (
  input  logic        ck,
  input  logic        rn,
  univ_sreg_if.slave  bus
);

  logic           accept, step;
  logic [2:0]     mode_lat;
  logic [N*W-1:0] out_q, out_d;
  logic [N*W-1:0] pin_q, pin_d;
  logic [W-1:0]   sout_c;

  univ_sreg_ctrl #(.CW(CW)) u_ctrl (
    .ck       (ck),
    .rn       (rn),
    .start    (bus.start),
    .mode     (bus.mode),
    .cnt      (bus.cnt),
    .accept   (accept),
    .busy     (bus.busy),
    .done     (bus.done),
    .step     (step),
    .mode_lat (mode_lat)
  );

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) begin
      out_q <= '0;
      pin_q <= '0;
    end else begin
      out_q <= out_d;
      pin_q <= pin_d;
    end
  end

  // Lane k lives at [k*W +: W]; "right" moves data toward lane 0.
  always_comb begin
    pin_d = pin_q;
    if (accept) pin_d = bus.pin;
    out_d = out_q;
    if (step) begin
      case (mode_lat)
        MODE_SHR:  out_d = {bus.sin, out_q[N*W-1:W]};
        MODE_SHL:  out_d = {out_q[(N-1)*W-1:0], bus.sin};
        MODE_ROR:  out_d = {out_q[W-1:0], out_q[N*W-1:W]};
        MODE_ROL:  out_d = {out_q[(N-1)*W-1:0], out_q[N*W-1:(N-1)*W]};
        MODE_LOAD: out_d = pin_q;
        default:   out_d = out_q;
      endcase
    end
  end

  // Lane that would be pushed out by the next edge of the latched mode
  always_comb begin
    case (mode_lat)
      MODE_SHR, MODE_ROR: sout_c = out_q[W-1:0];
      MODE_SHL, MODE_ROL: sout_c = out_q[N*W-1:(N-1)*W];
      default:            sout_c = '0;
    endcase
  end

  assign bus.out  = out_q;
  assign bus.sout = sout_c;

`ifdef UNIV_SREG_PARITY_EN
  logic par_q, par_d;

  // Computed from the next value so par tracks out on the same edge
  always_comb par_d = ^out_d;

  always_ff @(posedge ck or negedge rn) begin
    if (!rn) par_q <= 1'b0;
    else     par_q <= par_d;
  end

  assign bus.par = par_q;
`endif

endmodule

// File: tb/tb_univ_sreg.sv
// tb/tb_univ_sreg.sv - directed table-driven bench for univ_sreg (N=4, W=1, CW=8)
module tb_univ_sreg;
  import univ_sreg_pkg::*;

  logic ck = 1'b0;
  logic rn = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 ck = ~ck;

  univ_sreg_if #(.N(4), .W(1), .CW(8)) bus ();

  univ_sreg #(.N(4), .W(1), .CW(8)) dut (
    .ck  (ck),
    .rn  (rn),
    .bus (bus)
  );

  typedef struct {
    logic       start;
    logic [2:0] mode;
    logic [7:0] cnt;
    logic       sin;
    logic [3:0] pin;
    logic [3:0] e_out;
    logic       e_busy;
    logic       e_done;
    logic       e_sout;
  } vec_t;

  vec_t tbl [17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic set_in(input logic s, input logic [2:0] m, input logic [7:0] c,
                        input logic si, input logic [3:0] p);
    bus.start = s;
    bus.mode  = m;
    bus.cnt   = c;
    bus.sin   = si;
    bus.pin   = p;
  endtask

  // Called just after an accepting edge; counts busy cycles until done shows
  task automatic wait_done(input int limit, output int nb, output bit ok);
    nb = 0;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.done) begin
        ok = 1'b1;
        break;
      end
      if (bus.busy) nb++;
      tick();
    end
  endtask

  initial begin
    int  nb;
    bit  ok;
    bit  saw_done;

    tbl[0]  = '{1'b1, MODE_SHR,  8'd2, 1'b1, 4'h0,    4'b0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, MODE_SHR,  8'd0, 1'b1, 4'h0,    4'b1000, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, MODE_HOLD, 8'd0, 1'b1, 4'h0,    4'b1100, 1'b0, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0,    4'b1100, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, MODE_LOAD, 8'd7, 1'b0, 4'b1010, 4'b1100, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0,    4'b1010, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0,    4'b1010, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, MODE_ROR,  8'd1, 1'b0, 4'h0,    4'b1010, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0,    4'b0101, 1'b0, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0,    4'b0101, 1'b0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, MODE_ROL,  8'd3, 1'b0, 4'h0,    4'b0101, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0,    4'b1010, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0,    4'b0101, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0,    4'b1010, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b1, MODE_SHR,  8'd5, 1'b1, 4'h0,    4'b1010, 1'b0, 1'b0, 1'b1};
    tbl[15] = '{1'b1, MODE_SHR,  8'd0, 1'b1, 4'h0,    4'b1010, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0,    4'b1010, 1'b0, 1'b0, 1'b0};

    set_in(1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0);
    #12;
    chk("rst_out",  32'(bus.out),  32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_done", 32'(bus.done), 32'h0);
    chk("rst_sout", 32'(bus.sout), 32'h0);
`ifdef UNIV_SREG_PARITY_EN
    chk("rst_par",  32'(bus.par),  32'h0);
`endif
    rn = 1'b1;
    tick();

    for (int i = 0; i < 17; i++) begin
      set_in(tbl[i].start, tbl[i].mode, tbl[i].cnt, tbl[i].sin, tbl[i].pin);
      tick();
      chk($sformatf("row%0d_out", i),  32'(bus.out),  32'(tbl[i].e_out));
      chk($sformatf("row%0d_busy", i), 32'(bus.busy), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d_done", i), 32'(bus.done), 32'(tbl[i].e_done));
      chk($sformatf("row%0d_sout", i), 32'(bus.sout), 32'(tbl[i].e_sout));
    end

    // Abort mid-SHR: reset forces everything at once, no done afterwards
    set_in(1'b1, MODE_SHR, 8'd5, 1'b1, 4'h0);
    tick();
    set_in(1'b0, MODE_HOLD, 8'd0, 1'b1, 4'h0);
    tick();
    chk("abort_pre_out", 32'(bus.out), 32'b1101);
    #2 rn = 1'b0;
    #1;
    chk("abort_out",  32'(bus.out),  32'h0);
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    #3 rn = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'h0);

    // HOLD cnt=3 with start re-pulsed during RUN: original count completes
    set_in(1'b1, MODE_HOLD, 8'd3, 1'b0, 4'h0);
    tick();
    set_in(1'b1, MODE_SHR, 8'd1, 1'b1, 4'hF);
    wait_done(20, nb, ok);
    set_in(1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0);
    chk("rerun_done_seen", 32'(ok), 32'h1);
    chk("rerun_busy_cycles", 32'(nb), 32'd3);
    chk("rerun_out", 32'(bus.out), 32'h0);
    tick();
    chk("rerun_idle_busy", 32'(bus.busy), 32'h0);

    // Largest count runs full length with no wrap
    set_in(1'b1, MODE_HOLD, 8'd255, 1'b0, 4'h0);
    tick();
    set_in(1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0);
    wait_done(300, nb, ok);
    chk("max_done_seen", 32'(ok), 32'h1);
    chk("max_busy_cycles", 32'(nb), 32'd255);
    tick();

`ifdef UNIV_SREG_PARITY_EN
    set_in(1'b1, MODE_LOAD, 8'd0, 1'b0, 4'b0111);
    tick();
    set_in(1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0);
    wait_done(10, nb, ok);
    chk("par_load_out", 32'(bus.out), 32'b0111);
    chk("par_load_par", 32'(bus.par), 32'h1);
    tick();
    set_in(1'b1, MODE_SHR, 8'd1, 1'b0, 4'h0);
    tick();
    set_in(1'b0, MODE_HOLD, 8'd0, 1'b0, 4'h0);
    wait_done(10, nb, ok);
    chk("par_shr_out", 32'(bus.out), 32'b0011);
    chk("par_shr_par", 32'(bus.par), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
